// File: rtl/imul_pkg.sv
// imul_pkg: definitions shared by the imul_sequencer slice.
//   OPERAND_W / RESULT_W - operand and product widths (16 and 32 bits)
//   SETTLE_MIN/MAX       - legal range of the SETTLE_CYCLES parameter
//   COUNT_W              - width of the settle counter (holds up to SETTLE_MAX-1)
//   seqState_t           - sequencer FSM state encodings
package imul_pkg;

  localparam int OPERAND_W  = 16;
  localparam int RESULT_W   = 32;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int COUNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DONE   = 2'b10
  } seqState_t;

endpackage

// File: rtl/imul_core.sv
// imul_core: 16x16 unsigned combinational array multiplier.
// Each set bit of iB contributes iA shifted to that bit position; the
// partial products are summed at full 32-bit width, so nothing is truncated.
//   iA, iB   - unsigned operands (must come from registered sources)
//   oProduct - full-width unsigned product
module imul_core
  import imul_pkg::*;
(
  input  logic [OPERAND_W-1:0] iA,
  input  logic [OPERAND_W-1:0] iB,
  output logic [RESULT_W-1:0]  oProduct
);

  logic [RESULT_W-1:0] partialSum;

  always_comb begin
    partialSum = '0;
    for (int i = 0; i < OPERAND_W; i++) begin
      if (iB[i]) begin
        partialSum = partialSum + (RESULT_W'(iA) << i);
      end
    end
    oProduct = partialSum;
  end

endmodule

// File: rtl/imul_sequencer.sv
// imul_sequencer: accepts an unsigned 16x16 operand pair, lets the
// combinational product settle for SETTLE_CYCLES edges (legal 1..15), then
// presents the registered 32-bit result until downstream takes it.
//
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - asynchronous, active-low reset
//   iValid / oReady  - upstream handshake, operands iA / iB
//   oValid  / iReady - downstream handshake, result oResult
//   oBusy   - high whenever the FSM is not IDLE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. oReady is high only in IDLE, oValid only in DONE; each depends
// only on registered state, never on the partner's valid/ready. oResult is
// stable for as long as oValid is high.
//
// Build option: define IMUL_ACC_EN for accumulate mode. This adds iAccClr
// (clear accumulator, honoured in IDLE only) and oOverflow (sticky carry
// out of bit 31); oResult then carries the running sum of products.
module imul_sequencer
  import imul_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iValid,
  output logic        oReady,
  input  logic [15:0] iA,
  input  logic [15:0] iB,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oResult,
  output logic        oBusy
`ifdef IMUL_ACC_EN
  ,
  input  logic        iAccClr,
  output logic        oOverflow
`endif
);

  // Loaded at acceptance; SETTLE ends on the edge where it reads zero,
  // which makes the result visible exactly SETTLE_CYCLES edges later.
  localparam logic [COUNT_W-1:0] CNT_LOAD = COUNT_W'(SETTLE_CYCLES - 1);

  seqState_t              stateQ;
  seqState_t              stateD;
  logic [COUNT_W-1:0]     settleCount;
  logic [OPERAND_W-1:0]   opA;
  logic [OPERAND_W-1:0]   opB;
  logic [RESULT_W-1:0]    resultQ;
  logic [RESULT_W-1:0]    product;
  logic [RESULT_W-1:0]    nextResult;
  logic                   settleDone;

  imul_core uCore (
    .iA       (opA),
    .iB       (opB),
    .oProduct (product)
  );

  assign settleDone = (stateQ == SETTLE) && (settleCount == '0);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    stateD = stateQ;
    oReady = 1'b0;
    oValid = 1'b0;
    oBusy  = 1'b1;
    case (stateQ)
      IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) stateD = SETTLE;
      end
      SETTLE: begin
        if (settleCount == '0) stateD = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) stateD = IDLE;
      end
      default: begin
        // Unused encoding: recover to IDLE on the next edge.
        stateD = IDLE;
      end
    endcase
  end

  // Operand capture, settle counter and result register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      settleCount <= '0;
      opA         <= '0;
      opB         <= '0;
      resultQ     <= '0;
    end else begin
      if (stateQ == IDLE && iValid) begin
        opA         <= iA;
        opB         <= iB;
        settleCount <= CNT_LOAD;
      end else if (stateQ == SETTLE) begin
        if (settleCount == '0) begin
          resultQ <= nextResult;
        end else begin
          settleCount <= settleCount - 1'b1;
        end
      end
    end
  end

`ifdef IMUL_ACC_EN
  logic [RESULT_W-1:0] accQ;
  logic                overflowQ;
  logic [RESULT_W:0]   accSum;

  // One extra bit to catch the carry out of bit 31.
  assign accSum     = {1'b0, accQ} + {1'b0, product};
  assign nextResult = accSum[RESULT_W-1:0];

  // A clear in IDLE lands on the acceptance edge itself, so the operation
  // accepted on that edge starts from an empty accumulator.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      accQ      <= '0;
      overflowQ <= 1'b0;
    end else if (stateQ == IDLE && iAccClr) begin
      accQ      <= '0;
      overflowQ <= 1'b0;
    end else if (settleDone) begin
      accQ <= accSum[RESULT_W-1:0];
      if (accSum[RESULT_W]) overflowQ <= 1'b1;
    end
  end

  assign oOverflow = overflowQ;
`else
  assign nextResult = product;
`endif

  assign oResult = resultQ;

endmodule

// File: tb/tb_imul_sequencer.sv
// Self-checking bench for imul_sequencer (SETTLE_CYCLES = 2).
// Define IMUL_ACC_EN to build and check the accumulate variant.
module tb_imul_sequencer;

  localparam int SETTLE = 2;
  localparam int BOUND  = 50;

  logic        Clock;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oValid;
  logic        iReady;
  logic [31:0] oResult;
  logic        oBusy;
`ifdef IMUL_ACC_EN
  logic        iAccClr;
  logic        oOverflow;
`endif

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  imul_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iValid  (iValid),
    .oReady  (oReady),
    .iA      (iA),
    .iB      (iB),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oBusy   (oBusy)
`ifdef IMUL_ACC_EN
    ,
    .iAccClr   (iAccClr),
    .oOverflow (oOverflow)
`endif
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- driver tasks ----------------
  // Called at posedge+1 in IDLE; the next edge accepts the pair.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b);
    iA     = a;
    iB     = b;
    iValid = 1'b1;
    @(posedge Clock); #1;
    iValid = 1'b0;
  endtask

  // Counts edges until oValid is seen (0 if already high).
  task automatic wait_valid(output int edges, output bit timedOut);
    edges = 0;
    while (!oValid && edges < BOUND) begin
      @(posedge Clock); #1;
      edges++;
    end
    timedOut = !oValid;
  endtask

  task automatic release_result();
    iReady = 1'b1;
    @(posedge Clock); #1;
    iReady = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    #3;
    vectors++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0 || oResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: oReady=%b oValid=%b oBusy=%b oResult=%h, required 1 0 0 00000000",
               oReady, oValid, oBusy, oResult);
    end
    repeat (2) @(posedge Clock);
    #1;
    vectors++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: oReady=%b oValid=%b oBusy=%b, required 1 0 0", oReady, oValid, oBusy);
    end
  endtask

  task automatic test_basic();
    int edges;
    bit timedOut;
    logic [31:0] exp;
    Reset = 1'b1;
    // First edge after release must already accept.
    exp_q.push_back(32'h0001_2340);
    accept_op(16'h1234, 16'h0010);
    vectors++;
    if (oBusy !== 1'b1 || oReady !== 1'b0) begin
      miscompares++;
      $display("FAIL first_accept: oBusy=%b oReady=%b, required 1 0", oBusy, oReady);
    end
    wait_valid(edges, timedOut);
    vectors++;
    if (timedOut || edges != SETTLE) begin
      miscompares++;
      $display("FAIL basic_latency: edges=%0d timeout=%0b, required %0d", edges, timedOut, SETTLE);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (oResult !== exp) begin
      miscompares++;
      $display("FAIL basic_result: oResult=%h, required %h", oResult, exp);
    end
    release_result();
    vectors++;
    if (oValid !== 1'b0 || oReady !== 1'b1 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_release: oValid=%b oReady=%b oBusy=%b, required 0 1 0", oValid, oReady, oBusy);
    end
  endtask

  task automatic test_hold();
    int edges;
    bit timedOut;
    int bad;
    logic [31:0] exp;
    exp_q.push_back(32'hFFFE_0001);
    accept_op(16'hFFFF, 16'hFFFF);
    wait_valid(edges, timedOut);
    exp = exp_q.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (oValid !== 1'b1 || oResult !== exp || oReady !== 1'b0) bad++;
      @(posedge Clock); #1;
    end
    vectors++;
    if (timedOut || bad != 0) begin
      miscompares++;
      $display("FAIL hold_stable: bad_cycles=%0d oResult=%h, required 0 bad cycles and %h", bad, oResult, exp);
    end
    vectors++;
    if (oValid !== 1'b1 || oResult !== exp) begin
      miscompares++;
      $display("FAIL hold_end: oValid=%b oResult=%h, required 1 %h", oValid, oResult, exp);
    end
    release_result();
    vectors++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_to_idle: oValid=%b oBusy=%b, required 0 0", oValid, oBusy);
    end
  endtask

  task automatic test_ignore();
    int n;
    int readyHigh;
    logic [31:0] exp;
    exp_q.push_back(32'(16'h00AB) * 32'(16'h0CD0));
    accept_op(16'h00AB, 16'h0CD0);
    n = 0;
    readyHigh = 0;
    while (!oValid && n < BOUND) begin
      if (oReady !== 1'b0) readyHigh++;
      iValid = 1'b1;
      iA     = 16'($urandom_range(0, 16'hFFFF));
      iB     = 16'($urandom_range(0, 16'hFFFF));
      @(posedge Clock); #1;
      n++;
    end
    iValid = 1'b0;
    vectors++;
    if (readyHigh != 0 || !oValid) begin
      miscompares++;
      $display("FAIL ignore_ready: readyHigh_cycles=%0d oValid=%b, required 0 and 1", readyHigh, oValid);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (oResult !== exp) begin
      miscompares++;
      $display("FAIL ignore_result: oResult=%h, required %h", oResult, exp);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int sawValid;
    accept_op(16'h4321, 16'h0077);
    Reset = 1'b0;
    #1;
    vectors++;
    if (oResult !== 32'h0 || oValid !== 1'b0 || oReady !== 1'b1 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: oResult=%h oValid=%b oReady=%b oBusy=%b, required 00000000 0 1 0",
               oResult, oValid, oReady, oBusy);
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      if (oValid !== 1'b0) sawValid++;
    end
    vectors++;
    if (sawValid != 0 || oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_stale: oValid_cycles=%0d oReady=%b, required 0 1", sawValid, oReady);
    end
  endtask

  // iValid and iReady held high: a new pair every SETTLE+2 cycles.
  task automatic test_back_to_back();
    int lastAcc;
    int gapBad;
    int edges;
    bit timedOut;
    logic [31:0] exp;
    lastAcc = -1;
    gapBad  = 0;
    iValid  = 1'b1;
    iReady  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (oValid) begin
        exp = exp_q.pop_front();
        vectors++;
        if (oResult !== exp) begin
          miscompares++;
          $display("FAIL b2b_result: oResult=%h, required %h", oResult, exp);
        end
      end
      if (oReady) begin
        iA = 16'($urandom_range(0, 16'hFFFF));
        iB = 16'($urandom_range(0, 16'hFFFF));
        if (cyc % 3 == 0) iA = 16'hFFFF;
        exp_q.push_back(32'(iA) * 32'(iB));
        if (lastAcc >= 0 && cyc - lastAcc != SETTLE + 2) gapBad++;
        lastAcc = cyc;
      end
      @(posedge Clock); #1;
    end
    iValid = 1'b0;
    vectors++;
    if (gapBad != 0 || lastAcc < 0) begin
      miscompares++;
      $display("FAIL b2b_interval: bad_gaps=%0d lastAcc=%0d, required 0 bad gaps of %0d", gapBad, lastAcc, SETTLE + 2);
    end
    while (exp_q.size() > 0) begin
      wait_valid(edges, timedOut);
      exp = exp_q.pop_front();
      vectors++;
      if (timedOut || oResult !== exp) begin
        miscompares++;
        $display("FAIL b2b_drain: oResult=%h timeout=%0b, required %h", oResult, timedOut, exp);
      end
      @(posedge Clock); #1;
    end
    iReady = 1'b0;
  endtask

`ifdef IMUL_ACC_EN
  task automatic test_acc();
    int edges;
    bit timedOut;
    logic [32:0] accModel;
    logic [31:0] exp;
    logic [15:0] aTab[4];
    logic [15:0] bTab[4];
    bit          clrTab[4];
    logic        ovfModel;
    aTab = '{16'd3, 16'd5, 16'hFFFF, 16'hFFFF};
    bTab = '{16'd4, 16'd6, 16'hFFFF, 16'hFFFF};
    clrTab = '{1'b1, 1'b0, 1'b1, 1'b0};
    accModel = '0;
    ovfModel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (clrTab[k]) begin
        accModel = '0;
        ovfModel = 1'b0;
      end
      accModel = {1'b0, accModel[31:0]} + 33'(32'(aTab[k]) * 32'(bTab[k]));
      if (accModel[32]) ovfModel = 1'b1;
      exp_q.push_back(accModel[31:0]);
      iAccClr = clrTab[k];
      accept_op(aTab[k], bTab[k]);
      iAccClr = 1'b1; // must be ignored outside IDLE
      wait_valid(edges, timedOut);
      iAccClr = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (timedOut || oResult !== exp || oOverflow !== ovfModel) begin
        miscompares++;
        $display("FAIL acc_step%0d: oResult=%h oOverflow=%b, required %h %b", k, oResult, oOverflow, exp, ovfModel);
      end
      release_result();
    end
    iAccClr = 1'b1;
    @(posedge Clock); #1;
    iAccClr = 1'b0;
    vectors++;
    if (oOverflow !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_clear: oOverflow=%b, required 0", oOverflow);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset  = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iA     = '0;
    iB     = '0;
`ifdef IMUL_ACC_EN
    iAccClr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_hold();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef IMUL_ACC_EN
    test_acc();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
